// File: rtl/cunit_pkg.sv
// Shared opcodes, ALU-op encodings and control bundle types for the pipelined control unit.
package cunit_pkg;

   localparam int unsigned AOP_WIDTH = 3;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [AOP_WIDTH-1:0] AOP_NONE  = 3'b000;
   localparam logic [AOP_WIDTH-1:0] AOP_SUB   = 3'b001;
   localparam logic [AOP_WIDTH-1:0] AOP_RTYPE = 3'b010;
   localparam logic [AOP_WIDTH-1:0] AOP_ADD   = 3'b011;
   localparam logic [AOP_WIDTH-1:0] AOP_SLT   = 3'b100;
   localparam logic [AOP_WIDTH-1:0] AOP_AND   = 3'b101;
   localparam logic [AOP_WIDTH-1:0] AOP_OR    = 3'b110;

   typedef struct packed {
      logic                 regds;
      logic                 alusrc;
      logic [AOP_WIDTH-1:0] aop;
      logic                 branch;
      logic                 mread;
      logic                 mwrite;
      logic                 mtor;
      logic                 urw;
   } ctrl_t;

   typedef struct packed {
      logic branch;
      logic mread;
      logic mwrite;
      logic mtor;
      logic urw;
   } mem_ctrl_t;

   typedef struct packed {
      logic mtor;
      logic urw;
   } wb_ctrl_t;

   localparam ctrl_t     CTRL_NOP = '0;
   localparam mem_ctrl_t MEM_NOP  = '0;
   localparam wb_ctrl_t  WB_NOP   = '0;

   // Immediate ALU instructions share everything but the ALU op.
   function automatic ctrl_t itype_ctrl(input logic [AOP_WIDTH-1:0] aop);
      ctrl_t c;
      c        = CTRL_NOP;
      c.alusrc = 1'b1;
      c.aop    = aop;
      c.urw    = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/cunit_dec.sv
// Combinational ID-stage opcode decoder; J decode and jump_o exist only with CUNIT_JUMP_EN.
module cunit_dec
   import cunit_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic       valid_i,
   output ctrl_t      ctrl_o,
`ifdef CUNIT_JUMP_EN
   output logic       jump_o,
`endif
   output logic       illegal_o
);

`ifdef CUNIT_JUMP_EN
   logic jump_s;
   assign jump_o = jump_s;
`endif

   // Opcode to control bundle; unknown opcodes yield a NOP plus the illegal flag.
   always_comb begin
      ctrl_o    = CTRL_NOP;
      illegal_o = 1'b0;
`ifdef CUNIT_JUMP_EN
      jump_s    = 1'b0;
`endif
      if (valid_i) begin
         case (op_i)
            OP_R: begin
               ctrl_o.regds = 1'b1;
               ctrl_o.aop   = AOP_RTYPE;
               ctrl_o.urw   = 1'b1;
            end
            OP_LW: begin
               ctrl_o.alusrc = 1'b1;
               ctrl_o.aop    = AOP_ADD;
               ctrl_o.mread  = 1'b1;
               ctrl_o.urw    = 1'b1;
               ctrl_o.mtor   = 1'b1;
            end
            OP_SW: begin
               ctrl_o.alusrc = 1'b1;
               ctrl_o.aop    = AOP_ADD;
               ctrl_o.mwrite = 1'b1;
            end
            OP_BEQ: begin
               ctrl_o.aop    = AOP_SUB;
               ctrl_o.branch = 1'b1;
            end
            OP_ADDI: ctrl_o = itype_ctrl(AOP_ADD);
            OP_ANDI: ctrl_o = itype_ctrl(AOP_AND);
            OP_ORI:  ctrl_o = itype_ctrl(AOP_OR);
            OP_SLTI: ctrl_o = itype_ctrl(AOP_SLT);
`ifdef CUNIT_JUMP_EN
            OP_J:    jump_s = 1'b1;
`endif
            default: illegal_o = 1'b1;
         endcase
      end else begin
         ctrl_o = CTRL_NOP;
      end
   end

endmodule

// File: rtl/cunit_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall, branch flush.
// Optional J support via CUNIT_JUMP_EN (adds jump_o).
module cunit_pipe
   import cunit_pkg::*;
#(
   parameter int unsigned AOP_W  = 3,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] rs_i,
   input  logic [REG_AW-1:0] rt_i,
   input  logic              branch_taken_i,
   output logic              stall_o,
   output logic              illegal_o,
   output logic              ex_regds_o,
   output logic              ex_alusrc_o,
   output logic [AOP_W-1:0]  ex_aop_o,
   output logic              mem_branch_o,
   output logic              mem_mread_o,
   output logic              mem_mwrite_o,
   output logic              wb_mtor_o,
   output logic              wb_urw_o,
`ifdef CUNIT_JUMP_EN
   output logic              jump_o,
`endif
   output logic [CNT_W-1:0]  stall_cnt_o
);

   ctrl_t             dec_ctrl_s;
   logic              dec_ill_s;
   logic              hazard_s;
   logic              stall_s;

   ctrl_t             idex_ctrl_q, idex_ctrl_d;
   logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
   logic              idex_ill_q, idex_ill_d;
   mem_ctrl_t         exmem_q, exmem_d;
   wb_ctrl_t          memwb_q, memwb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef CUNIT_JUMP_EN
   logic dec_jump_s;
`endif

   cunit_dec u_dec (
      .op_i      (op_i),
      .valid_i   (id_valid_i),
      .ctrl_o    (dec_ctrl_s),
`ifdef CUNIT_JUMP_EN
      .jump_o    (dec_jump_s),
`endif
      .illegal_o (dec_ill_s)
   );

   // Hazard detection and next state of every stage register and the stall counter.
   always_comb begin
      hazard_s = idex_ctrl_q.mread && (idex_rt_q != '0) &&
                 ((idex_rt_q == rs_i) || (idex_rt_q == rt_i));
      stall_s  = hazard_s && !branch_taken_i;

      idex_ctrl_d = dec_ctrl_s;
      idex_rt_d   = rt_i;
      idex_ill_d  = dec_ill_s;
      if (branch_taken_i || hazard_s) begin
         idex_ctrl_d = CTRL_NOP;
         idex_rt_d   = '0;
         idex_ill_d  = 1'b0;
      end else begin
         idex_ctrl_d = dec_ctrl_s;
      end

      exmem_d = '{branch: idex_ctrl_q.branch, mread: idex_ctrl_q.mread,
                  mwrite: idex_ctrl_q.mwrite, mtor: idex_ctrl_q.mtor,
                  urw: idex_ctrl_q.urw};
      if (branch_taken_i) begin
         exmem_d = MEM_NOP;
      end else begin
         exmem_d.urw = idex_ctrl_q.urw;
      end

      memwb_d = '{mtor: exmem_q.mtor, urw: exmem_q.urw};

      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stage registers; reset discards everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_ctrl_q <= CTRL_NOP;
         idex_rt_q   <= '0;
         idex_ill_q  <= 1'b0;
         exmem_q     <= MEM_NOP;
         memwb_q     <= WB_NOP;
         cnt_q       <= '0;
      end else begin
         idex_ctrl_q <= idex_ctrl_d;
         idex_rt_q   <= idex_rt_d;
         idex_ill_q  <= idex_ill_d;
         exmem_q     <= exmem_d;
         memwb_q     <= memwb_d;
         cnt_q       <= cnt_d;
      end
   end

   assign stall_o      = stall_s;
   assign illegal_o    = idex_ill_q;
   assign ex_regds_o   = idex_ctrl_q.regds;
   assign ex_alusrc_o  = idex_ctrl_q.alusrc;
   assign ex_aop_o     = AOP_W'(idex_ctrl_q.aop);
   assign mem_branch_o = exmem_q.branch;
   assign mem_mread_o  = exmem_q.mread;
   assign mem_mwrite_o = exmem_q.mwrite;
   assign wb_mtor_o    = memwb_q.mtor;
   assign wb_urw_o     = memwb_q.urw;
   assign stall_cnt_o  = cnt_q;

`ifdef CUNIT_JUMP_EN
   // A jump is suppressed while its own fetch slot is being held or squashed.
   assign jump_o = dec_jump_s && !stall_s && !branch_taken_i;
`endif

endmodule

// File: tb/tb_cunit_pipe.sv
// Self-checking bench for cunit_pipe: directed scenarios plus random traffic against a stage-occupancy model.
module tb_cunit_pipe;

   localparam int unsigned TB_CNT_W = 8;
   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
   localparam logic [5:0] T_ADDI = 6'b001000, T_ANDI = 6'b001100, T_ORI = 6'b001101, T_SLTI = 6'b001010;
   localparam logic [5:0] T_J = 6'b000010;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [5:0]          op_i = 6'd0;
   logic                id_valid_i = 1'b0;
   logic [4:0]          rs_i = 5'd0, rt_i = 5'd0;
   logic                branch_taken_i = 1'b0;
   logic                stall_o, illegal_o, ex_regds_o, ex_alusrc_o;
   logic [2:0]          ex_aop_o;
   logic                mem_branch_o, mem_mread_o, mem_mwrite_o, wb_mtor_o, wb_urw_o;
   logic [TB_CNT_W-1:0] stall_cnt_o;
`ifdef CUNIT_JUMP_EN
   logic                jump_o;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       live;
      logic [5:0] op;
      logic [4:0] rt;
   } ent_t;

   ent_t ex_m, mem_m, wb_m;
   int   cnt_m;

   always #5 clk = ~clk;

   cunit_pipe #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst), .op_i(op_i), .id_valid_i(id_valid_i),
      .rs_i(rs_i), .rt_i(rt_i), .branch_taken_i(branch_taken_i),
      .stall_o(stall_o), .illegal_o(illegal_o),
      .ex_regds_o(ex_regds_o), .ex_alusrc_o(ex_alusrc_o), .ex_aop_o(ex_aop_o),
      .mem_branch_o(mem_branch_o), .mem_mread_o(mem_mread_o), .mem_mwrite_o(mem_mwrite_o),
      .wb_mtor_o(wb_mtor_o), .wb_urw_o(wb_urw_o),
`ifdef CUNIT_JUMP_EN
      .jump_o(jump_o),
`endif
      .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_itype(input logic [5:0] op);
      return (op == T_ADDI) || (op == T_ANDI) || (op == T_ORI) || (op == T_SLTI);
   endfunction

   function automatic logic known(input logic [5:0] op);
      logic k;
      k = (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) || is_itype(op);
`ifdef CUNIT_JUMP_EN
      k = k || (op == T_J);
`endif
      return k;
   endfunction

   function automatic logic [2:0] spec_aop(input logic [5:0] op);
      case (op)
         T_R:               return 3'b010;
         T_LW, T_SW, T_ADDI: return 3'b011;
         T_BEQ:             return 3'b001;
         T_ANDI:            return 3'b101;
         T_ORI:             return 3'b110;
         T_SLTI:            return 3'b100;
         default:           return 3'b000;
      endcase
   endfunction

   function automatic logic m_hazard();
      return ex_m.live && (ex_m.op == T_LW) && (ex_m.rt != 5'd0) &&
             ((ex_m.rt == rs_i) || (ex_m.rt == rt_i));
   endfunction

   task automatic check_regs(input string pfx);
      logic [5:0] e, m, w;
      e = ex_m.op; m = mem_m.op; w = wb_m.op;
      chk({pfx, "_ex_regds"}, 32'(ex_regds_o), 32'(ex_m.live && e == T_R));
      chk({pfx, "_ex_alusrc"}, 32'(ex_alusrc_o),
          32'(ex_m.live && (e == T_LW || e == T_SW || is_itype(e))));
      chk({pfx, "_ex_aop"}, 32'(ex_aop_o), 32'(ex_m.live ? spec_aop(e) : 3'b000));
      chk({pfx, "_illegal"}, 32'(illegal_o), 32'(ex_m.live && !known(e)));
      chk({pfx, "_mem_branch"}, 32'(mem_branch_o), 32'(mem_m.live && m == T_BEQ));
      chk({pfx, "_mem_mread"}, 32'(mem_mread_o), 32'(mem_m.live && m == T_LW));
      chk({pfx, "_mem_mwrite"}, 32'(mem_mwrite_o), 32'(mem_m.live && m == T_SW));
      chk({pfx, "_wb_mtor"}, 32'(wb_mtor_o), 32'(wb_m.live && w == T_LW));
      chk({pfx, "_wb_urw"}, 32'(wb_urw_o),
          32'(wb_m.live && (w == T_R || w == T_LW || is_itype(w))));
      chk({pfx, "_stall_cnt"}, 32'(stall_cnt_o), 32'(cnt_m));
   endtask

   task automatic model_clear();
      ex_m = '0; mem_m = '0; wb_m = '0; cnt_m = 0;
   endtask

   // Apply ID inputs and check the combinational outputs for this cycle.
   task automatic drive(input logic [5:0] op, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic bt);
      logic st;
      op_i = op; id_valid_i = v; rs_i = rs; rt_i = rt; branch_taken_i = bt;
      #1;
      st = m_hazard() && !bt;
      chk("stall", 32'(stall_o), 32'(st));
`ifdef CUNIT_JUMP_EN
      chk("jump", 32'(jump_o), 32'(v && op == T_J && !st && !bt));
`endif
   endtask

   // Advance one clock edge in both model and DUT, then check registered outputs.
   task automatic tick();
      ent_t nex, nmem, nwb;
      logic hz;
      hz = m_hazard();
      if (hz && !branch_taken_i && cnt_m < (1 << TB_CNT_W) - 1) cnt_m++;
      nex.live = id_valid_i && !branch_taken_i && !hz;
      nex.op   = op_i;
      nex.rt   = rt_i;
      nmem     = branch_taken_i ? '0 : ex_m;
      nwb      = mem_m;
      @(posedge clk);
      ex_m = nex; mem_m = nmem; wb_m = nwb;
      #1;
      check_regs("cyc");
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      model_clear();
      check_regs("rst");
      chk("rst_stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [5:0] ops [10] = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_ANDI, T_ORI, T_SLTI, T_J, 6'b111111};

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_regs("init");
      @(negedge clk);
      rst = 1'b0;

      // R-type stream interrupted by an asynchronous reset
      for (int i = 0; i < 4; i++) begin
         drive(T_R, 1'b1, 5'd1, 5'd2, 1'b0);
         tick();
      end
      chk("pre_rst_wb_urw", 32'(wb_urw_o), 32'd1);
      #2;
      async_reset();
      chk("post_rst_wb_urw", 32'(wb_urw_o), 32'd0);

      // LW rt=5 followed by a user of $5
      drive(T_LW, 1'b1, 5'd0, 5'd5, 1'b0);
      tick();
      drive(T_R, 1'b1, 5'd5, 5'd6, 1'b0);
      chk("lu_stall_on", 32'(stall_o), 32'd1);
      tick();
      chk("lu_bubble_regds", 32'(ex_regds_o), 32'd0);
      chk("lu_bubble_aop", 32'(ex_aop_o), 32'd0);
      chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
      drive(T_R, 1'b1, 5'd5, 5'd6, 1'b0);
      chk("lu_stall_once", 32'(stall_o), 32'd0);
      tick();

      // LW to $0 never stalls
      drive(T_LW, 1'b1, 5'd0, 5'd0, 1'b0);
      tick();
      drive(T_R, 1'b1, 5'd0, 5'd0, 1'b0);
      chk("rt0_no_stall", 32'(stall_o), 32'd0);
      tick();

      // Taken branch in MEM overrides a pending load-use stall
      drive(T_BEQ, 1'b1, 5'd1, 5'd2, 1'b0);
      tick();
      drive(T_LW, 1'b1, 5'd0, 5'd7, 1'b0);
      tick();
      drive(T_R, 1'b1, 5'd7, 5'd0, 1'b1);
      chk("flush_stall", 32'(stall_o), 32'd0);
      tick();
      chk("flush_ex_regds", 32'(ex_regds_o), 32'd0);
      chk("flush_mem_mread", 32'(mem_mread_o), 32'd0);

      // Unknown opcode raises illegal_o, then a flush clears it
      drive(6'b111111, 1'b1, 5'd0, 5'd0, 1'b0);
      tick();
      chk("ill_set", 32'(illegal_o), 32'd1);
      chk("ill_ex_aop", 32'(ex_aop_o), 32'd0);
      drive(T_R, 1'b1, 5'd0, 5'd0, 1'b1);
      tick();
      chk("ill_clear", 32'(illegal_o), 32'd0);

      // J opcode
      drive(T_J, 1'b1, 5'd0, 5'd0, 1'b0);
`ifdef CUNIT_JUMP_EN
      chk("j_jump", 32'(jump_o), 32'd1);
      tick();
      chk("j_no_illegal", 32'(illegal_o), 32'd0);
`else
      tick();
      chk("j_illegal", 32'(illegal_o), 32'd1);
`endif

      // Random traffic; small register range makes hazards frequent
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 4) == 0 ? 6'($urandom) : ops[$urandom_range(0, 9)],
               $urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 9) == 0);
         tick();
      end

      // Drive the stall counter well past saturation
      for (int i = 0; i < 2 * ((1 << TB_CNT_W) + 3); i++) begin
         drive(T_LW, 1'b1, 5'd3, 5'd3, 1'b0);
         tick();
      end
      chk("cnt_saturated", 32'(stall_cnt_o), 32'((1 << TB_CNT_W) - 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cunit_pipe.md
# cunit_pipe

Pipelined successor to the single-cycle main control decoder. Decodes the 6-bit opcode in ID, carries the control bundle through ID/EX, EX/MEM and MEM/WB stage registers, detects load-use hazards (stall plus bubble) and squashes younger control on a taken branch. Sits between the IF/ID register and the datapath stage registers of the 5-stage MIPS core, and owns all stage-local control bits.

## Interface
- AOP_W, 3, ALU-op field width
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_i  in  6  opcode of the instruction in ID
- id_valid_i  in  1  ID holds a real instruction
- rs_i, rt_i  in  REG_AW  source register fields of the instruction in ID
- branch_taken_i  in  1  branch resolved taken in MEM this cycle
- stall_o  out  1  hold PC and IF/ID this cycle
- illegal_o  out  1  registered; unknown opcode accepted into EX
- ex_regds_o, ex_alusrc_o  out  1  EX-stage controls
- ex_aop_o  out  AOP_W  EX-stage ALU op
- mem_branch_o, mem_mread_o, mem_mwrite_o  out  1  MEM-stage controls
- wb_mtor_o, wb_urw_o  out  1  WB-stage controls (MtoR=1 selects memory data)
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Decode (combinational, ID):
  - R 000000: RegDs1 ALUsrc0 AOp010 Urw1 MtoR0
  - LW 100011: RegDs0 ALUsrc1 AOp011 MRead1 Urw1 MtoR1
  - SW 101011: ALUsrc1 AOp011 MWrite1
  - BEQ 000100: AOp001 Branch1
  - ADDI 001000: AOp011
  - ANDI 001100: AOp101
  - ORI 001101: AOp110
  - SLTI 001010: AOp100
  - ADDI, ANDI, ORI and SLTI also drive RegDs0 ALUsrc1 Urw1 MtoR0.
  - Unlisted bits are 0, never x.
- Unknown opcode: full bundle is zero (NOP). The ID/EX illegal flag is set and reaches illegal_o one cycle later.
- id_valid_i=0: bundle forced to zero.
- Load-use hazard: asserted when ID/EX MRead=1, ID/EX rt != 0, and ID/EX rt equals rs_i or rt_i. Then stall_o=1 and ID/EX loads the zero bundle (bubble).
- Flush: when branch_taken_i=1, ID/EX and EX/MEM load zero bundles and the illegal flag clears. MEM/WB advances normally.
- stall_o = hazard & ~branch_taken_i. Flush wins over stall.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at all-ones.

## Timing
- Decode to ex_* outputs: 1 cycle. mem_* outputs: 2 cycles. wb_* outputs: 3 cycles.
- stall_o is combinational from current ID/EX state and inputs; no registered delay.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears the hazard on the next edge.
- Reset (asynchronous, any time): all stage registers zero, illegal_o=0, stall_cnt_o=0, stall_o=0. Mid-pipeline contents are discarded and no partial bundle survives.
- First edge after rst deasserts captures the ID decode normally.

## Configuration
- CUNIT_JUMP_EN defined:
  - Opcode 000010 (J) decodes to a NOP bundle plus the jump_o port (out, 1, combinational in ID).
  - jump_o=1 causes IF/ID to be flushed externally. It is masked to 0 during stall_o or branch_taken_i.
- CUNIT_JUMP_EN undefined:
  - No jump_o port.
  - 000010 is treated as illegal.

## Structure
- Package cunit_pkg holds:
  - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - AOp encodings
  - packed struct ctrl_t {regds, alusrc, aop, branch, mread, mwrite, mtor, urw}
  - constant CTRL_NOP
- One sub-module, cunit_dec: the pure combinational opcode-to-ctrl_t decoder plus the illegal flag.
- Stage registers, hazard logic and the counter live in cunit_pipe.

## Test plan
- Reset mid-stream: drive R-type on consecutive cycles, assert rst asynchronously. All outputs read 0 immediately, and stall_cnt_o=0.
- LW then dependent ADD: LW rt=5, next instruction rs=5. stall_o=1 for exactly one cycle, ex_* is all zero the following cycle, stall_cnt_o=1.
- LW writing rt=0 followed by a user of $0: stall_o stays 0.
- BEQ in MEM with branch_taken_i=1 while a LW hazard is present: stall_o=0, and ex_*/mem_* read zero next cycle.
- Opcode 111111: ex_* all zero and illegal_o=1 one cycle later; a flush on the next cycle clears illegal_o.
- Force 2^CNT_W+3 stall cycles: stall_cnt_o holds at all-ones. With CUNIT_JUMP_EN, opcode 000010 gives jump_o=1.
